// File: rtl/arch_trace_pkg.sv
// Shared types for the commit-trace path: lane count, default widths, queued entry layout.
// Pure declarations; no timing or flow control of its own.
package arch_trace_pkg;

  localparam int XLEN_DEF         = 64;
  localparam int ILEN_DEF         = 32;
  localparam int NUM_COMMIT_LANES = 2;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } commit_entry_t;

endpackage

// File: rtl/arch_trace_fifo_mem.sv
// Two-write/one-read entry array; writes land on the clock edge, read is combinational.
// No control or backpressure here: the caller guarantees the write slots are free.
module arch_trace_fifo_mem
  import arch_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr0_vld,
  input  logic [PTR_W-1:0] wr0_addr,
  input  commit_entry_t wr0_dat,
  input  logic          wr1_vld,
  input  logic [PTR_W-1:0] wr1_addr,
  input  commit_entry_t wr1_dat,
  input  logic [PTR_W-1:0] rd_addr,
  output commit_entry_t rd_dat
);

  commit_entry_t mem_q [DEPTH];

  // Both ports never target the same slot in one cycle, so order is irrelevant.
  always_ff @(posedge clock) begin
    if (wr0_vld) mem_q[wr0_addr] <= wr0_dat;
    if (wr1_vld) mem_q[wr1_addr] <= wr1_dat;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/arch_step_serializer.sv
// Serializes up to two retired instructions per cycle into one in-order step per cycle.
// Output is registered (pop decided on pre-edge occupancy); commit_ready drops below 2 free slots.
module arch_step_serializer
  import arch_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = XLEN_DEF,
  parameter int ILEN  = ILEN_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_COMMIT_LANES-1:0] commit_valid,
  input  logic [XLEN-1:0]             commit_pc0,
  input  logic [ILEN-1:0]             commit_inst0,
  input  logic [XLEN-1:0]             commit_pc1,
  input  logic [ILEN-1:0]             commit_inst1,
  output logic                        commit_ready,
  output logic                        step_valid,
  output logic [XLEN-1:0]             step_pc,
  output logic [ILEN-1:0]             step_inst,
  output logic [OCC_W-1:0]            occupancy,
  output logic                        overflow
);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr1_addr;
  logic [OCC_W-1:0] occ_q, free_cnt, n_acc;
  logic             acc0, acc1, drop, pop;
  commit_entry_t    wr0_dat, wr1_dat, rd_dat;

  assign free_cnt = OCC_W'(DEPTH) - occ_q;

  // Space check uses pre-edge occupancy only; lane 0 wins the last free slot.
  assign acc0  = commit_valid[0] && (free_cnt != '0);
  assign acc1  = commit_valid[1] &&
                 (commit_valid[0] ? (free_cnt >= OCC_W'(2)) : (free_cnt != '0));
  assign drop  = (commit_valid[0] && !acc0) || (commit_valid[1] && !acc1);
  assign n_acc = OCC_W'(acc0) + OCC_W'(acc1);
  assign pop   = (occ_q != '0);

  // Lane 1 packs directly behind lane 0, or takes wr_ptr when it retires alone.
  assign wr1_addr = acc0 ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

  assign wr0_dat.pc   = XLEN_DEF'(commit_pc0);
  assign wr0_dat.inst = ILEN_DEF'(commit_inst0);
  assign wr1_dat.pc   = XLEN_DEF'(commit_pc1);
  assign wr1_dat.inst = ILEN_DEF'(commit_inst1);

  arch_trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock    (clock),
    .wr0_vld  (acc0),
    .wr0_addr (wr_ptr_q),
    .wr0_dat  (wr0_dat),
    .wr1_vld  (acc1),
    .wr1_addr (wr1_addr),
    .wr1_dat  (wr1_dat),
    .rd_addr  (rd_ptr_q),
    .rd_dat   (rd_dat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      step_valid <= 1'b0;
      step_pc    <= '0;
      step_inst  <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PTR_W'(n_acc);
      occ_q      <= occ_q + n_acc - OCC_W'(pop);
      step_valid <= pop;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        step_pc   <= XLEN'(rd_dat.pc);
        step_inst <= ILEN'(rd_dat.inst);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign occupancy    = occ_q;
  assign commit_ready = (free_cnt >= OCC_W'(2));

endmodule

// File: tb/tb_arch_step_serializer.sv
// Directed-vector bench for arch_step_serializer with hand-computed expectations.
module tb_arch_step_serializer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  commit_valid = '0;
  logic [63:0] commit_pc0 = '0, commit_pc1 = '0;
  logic [31:0] commit_inst0 = '0, commit_inst1 = '0;
  logic        commit_ready, step_valid, overflow;
  logic [63:0] step_pc;
  logic [31:0] step_inst;
  logic [3:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  arch_step_serializer #(.DEPTH(8), .XLEN(64), .ILEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc0   (commit_pc0),
    .commit_inst0 (commit_inst0),
    .commit_pc1   (commit_pc1),
    .commit_inst1 (commit_inst1),
    .commit_ready (commit_ready),
    .step_valid   (step_valid),
    .step_pc      (step_pc),
    .step_inst    (step_inst),
    .occupancy    (occupancy),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] cv, input logic [63:0] p0, input logic [31:0] i0,
                       input logic [63:0] p1, input logic [31:0] i1);
    commit_valid = cv;
    commit_pc0   = p0;
    commit_inst0 = i0;
    commit_pc1   = p1;
    commit_inst1 = i1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_step_valid", 64'(step_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_ready", 64'(commit_ready), 64'd1);
    chk("rst_step_pc", step_pc, 64'd0);
    tick(); tick();
    reset = 1'b1;

    // Single lane
    drive(2'b01, 64'h8000_0000, 32'h0000_0013, 64'h0, 32'h0);
    tick();
    drive(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
    chk("sl_occ_after_write", 64'(occupancy), 64'd1);
    chk("sl_valid_early", 64'(step_valid), 64'd0);
    tick();
    chk("sl_valid", 64'(step_valid), 64'd1);
    chk("sl_pc", step_pc, 64'h8000_0000);
    chk("sl_inst", 64'(step_inst), 64'h13);
    chk("sl_occ_pop", 64'(occupancy), 64'd0);
    tick();
    chk("sl_valid_off", 64'(step_valid), 64'd0);
    chk("sl_occ_end", 64'(occupancy), 64'd0);
    chk("sl_pc_hold", step_pc, 64'h8000_0000);

    // Dual lane ordering
    drive(2'b11, 64'h1000, 32'h0000_0013, 64'h1004, 32'h0010_0093);
    tick();
    drive(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
    chk("dl_occ", 64'(occupancy), 64'd2);
    tick();
    chk("dl_v0", 64'(step_valid), 64'd1);
    chk("dl_pc0", step_pc, 64'h1000);
    chk("dl_inst0", 64'(step_inst), 64'h13);
    tick();
    chk("dl_v1", 64'(step_valid), 64'd1);
    chk("dl_pc1", step_pc, 64'h1004);
    chk("dl_inst1", 64'(step_inst), 64'h0010_0093);
    chk("dl_occ_end", 64'(occupancy), 64'd0);
    tick();
    chk("dl_valid_off", 64'(step_valid), 64'd0);

    // Lane 1 only; lane 0 payload must be ignored
    drive(2'b10, 64'hDEAD, 32'hDEAD, 64'h2004, 32'h0000_0033);
    tick();
    drive(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
    chk("l1_occ_peak", 64'(occupancy), 64'd1);
    tick();
    chk("l1_valid", 64'(step_valid), 64'd1);
    chk("l1_pc", step_pc, 64'h2004);
    chk("l1_inst", 64'(step_inst), 64'h33);
    chk("l1_occ_end", 64'(occupancy), 64'd0);

    // Fill: six back-to-back dual commits starting at slot 4 so the pointers wrap
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 64'h3000 + 64'(8*k), 32'h100 + 32'(2*k),
                   64'h3004 + 64'(8*k), 32'h101 + 32'(2*k));
      tick();
      chk($sformatf("fill_occ_%0d", k), 64'(occupancy), 64'(k + 2));
      chk($sformatf("fill_rdy_%0d", k), 64'(commit_ready), (k == 5) ? 64'd0 : 64'd1);
      if (k > 0) begin
        chk($sformatf("fill_pc_%0d", k), step_pc, 64'h3000 + 64'(4*(k-1)));
        chk($sformatf("fill_inst_%0d", k), 64'(step_inst), 64'h100 + 64'(k-1));
      end
    end

    // Overflow at occupancy 7: lane 0 kept, lane 1 dropped
    drive(2'b11, 64'h3060, 32'h200, 64'h3064, 32'h201);
    tick();
    drive(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
    chk("ov_flag", 64'(overflow), 64'd1);
    chk("ov_occ", 64'(occupancy), 64'd7);
    chk("ov_ready", 64'(commit_ready), 64'd0);
    chk("ov_pc", step_pc, 64'h3014);
    for (int j = 0; j < 7; j++) begin
      tick();
      chk($sformatf("drain_v_%0d", j), 64'(step_valid), 64'd1);
      chk($sformatf("drain_pc_%0d", j), step_pc, (j == 6) ? 64'h3060 : 64'h3018 + 64'(4*j));
    end
    chk("drain_occ", 64'(occupancy), 64'd0);
    chk("ov_sticky", 64'(overflow), 64'd1);
    tick();
    chk("drain_off", 64'(step_valid), 64'd0);
    chk("ov_sticky2", 64'(overflow), 64'd1);

    // Build occupancy 5, then assert reset between edges
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 64'h4000 + 64'(8*k), 32'h0, 64'h4004 + 64'(8*k), 32'h0);
      tick();
    end
    drive(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    chk("pre_rst_valid", 64'(step_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(step_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_ready", 64'(commit_ready), 64'd1);
    tick();
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("post_rst_v_%0d", j), 64'(step_valid), 64'd0);
      chk($sformatf("post_rst_occ_%0d", j), 64'(occupancy), 64'd0);
    end

    // Fresh commit after reset lands at slot 0 and emits cleanly
    drive(2'b01, 64'h5000, 32'h0000_0073, 64'h0, 32'h0);
    tick();
    drive(2'b00, 64'h0, 32'h0, 64'h0, 32'h0);
    tick();
    chk("post_rst_pc", step_pc, 64'h5000);
    chk("post_rst_inst", 64'(step_inst), 64'h73);
    chk("post_rst_valid", 64'(step_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
